// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with an internal bit timer that samples each bit at its centre.
// Build macro UART_RX_MAJORITY_EN selects 3-sample majority voting of the synchronised line.
module uart_rx #(
   parameter int CLKS_PER_BIT = 48
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_rxd,
   output logic [7:0] data,
   output logic       data_strobe,
   output logic       framing_error,
   output logic       busy
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          strobe_q, strobe_d;
   logic          ferr_q, ferr_d;
   logic          rxd_meta_q, rxd_sync_q;
   logic          sample;

   // Two-flop synchroniser; both flops reset to the idle (mark) level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
      end else begin
         // NOTE: non-blocking so the second flop sees the first flop's old value.
         rxd_meta_q <= serial_rxd;
         rxd_sync_q <= rxd_meta_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (reset) hist_q <= 2'b11;
      else       hist_q <= {hist_q[0], rxd_sync_q};
   end

   assign sample = (rxd_sync_q & hist_q[0]) | (rxd_sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign sample = rxd_sync_q;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      strobe_d  = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxd_sync_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_TERM) begin
               cnt_d = '0;
               if (sample) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_TERM) begin
               cnt_d     = '0;
               shift_d   = {sample, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_TERM) begin
               cnt_d = '0;
               if (sample) begin
                  data_d   = shift_q;
                  strobe_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_BREAK: begin
            // A line held low must return high before another frame can start.
            cnt_d = '0;
            if (rxd_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      data          = data_q;
      data_strobe   = strobe_q;
      framing_error = ferr_q;
      busy          = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx at 48 clocks per bit.
// Honours UART_RX_MAJORITY_EN for the sample-point glitch expectation.
module tb_uart_rx;

   localparam int C   = 48;
   localparam int H   = C / 2;
   localparam int LAT = 3 + H + 9 * C;   // start-drive negedge to strobe-visible negedge

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      logic [7:0] exp_data;
      int         exp_strobes;
      int         exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_rxd;
   logic [7:0] data;
   logic       data_strobe;
   logic       framing_error;
   logic       busy;

   int         cyc    = 0;
   int         n_vec  = 0;
   int         n_miss = 0;
   int         n_ferr = 0;
   int         n_both = 0;
   logic [7:0] rx_q[$];
   int         rx_cyc_q[$];
   vec_t       vecs[6];

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_rxd   (serial_rxd),
      .data         (data),
      .data_strobe  (data_strobe),
      .framing_error(framing_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_strobe) begin
         rx_q.push_back(data);
         rx_cyc_q.push_back(cyc);
      end
      if (framing_error) n_ferr <= n_ferr + 1;
      if (data_strobe && framing_error) n_both <= n_both + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge that ends the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit,
                             output int start_cyc);
      start_cyc  = cyc;
      serial_rxd = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rxd = b[i];
         if (i == glitch_bit) begin
            repeat (H) @(negedge clk);
            serial_rxd = ~b[i];
            @(negedge clk);
            serial_rxd = b[i];
            repeat (C - H - 1) @(negedge clk);
         end else begin
            repeat (C) @(negedge clk);
         end
      end
      serial_rxd = stop;
      repeat (C) @(negedge clk);
   endtask

   initial begin
      int         t0, t1, n0, f0;
      logic [7:0] b;
      logic [7:0] exp_glitch;

      vecs[0] = '{8'h41, 1'b1, 8'h41, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
      vecs[3] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
      vecs[4] = '{8'h5A, 1'b0, 8'hA5, 0, 1};
      vecs[5] = '{8'h80, 1'b1, 8'h80, 1, 0};

      reset      = 1'b1;
      serial_rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", data, 8'h00);
      check("reset_strobe", data_strobe, 1'b0);
      check("reset_ferr", framing_error, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_busy", busy, 1'b0);

      for (int v = 0; v < 6; v++) begin
         n0 = rx_q.size();
         f0 = n_ferr;
         send_frame(vecs[v].tx, vecs[v].stop, -1, t0);
         serial_rxd = 1'b1;
         repeat (C) @(negedge clk);
         check($sformatf("vec%0d_strobes", v), rx_q.size() - n0, vecs[v].exp_strobes);
         check($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
         check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
         if (rx_q.size() > n0)
            check($sformatf("vec%0d_latency", v), rx_cyc_q[rx_cyc_q.size()-1] - t0, LAT);
      end

      // Start glitch: 10 cycles low must be rejected at the half-bit sample.
      n0 = rx_q.size();
      f0 = n_ferr;
      t0 = cyc;
      serial_rxd = 1'b0;
      repeat (2) @(negedge clk);
      check("sglitch_busy_before", busy, 1'b0);
      @(negedge clk);
      check("sglitch_busy_rise", busy, 1'b1);
      repeat (7) @(negedge clk);
      serial_rxd = 1'b1;
      repeat (16) @(negedge clk);
      check("sglitch_busy_last", busy, 1'b1);
      @(negedge clk);
      check("sglitch_busy_fall", busy, 1'b0);
      repeat (C) @(negedge clk);
      check("sglitch_strobes", rx_q.size() - n0, 0);
      check("sglitch_ferr", n_ferr - f0, 0);

      // Back-to-back frames with a single stop bit.
      n0 = rx_q.size();
      send_frame(8'h0D, 1'b1, -1, t0);
      send_frame(8'h0A, 1'b1, -1, t1);
      serial_rxd = 1'b1;
      repeat (C) @(negedge clk);
      check("b2b_strobes", rx_q.size() - n0, 2);
      check("b2b_start_gap", t1 - t0, 10 * C);
      if (rx_q.size() >= n0 + 2) begin
         check("b2b_data0", rx_q[n0], 8'h0D);
         check("b2b_data1", rx_q[n0+1], 8'h0A);
         check("b2b_strobe_gap", rx_cyc_q[n0+1] - rx_cyc_q[n0], 10 * C);
      end

      // Framing error followed by a long break.
      send_frame(8'h41, 1'b1, -1, t0);
      n0 = rx_q.size();
      f0 = n_ferr;
      send_frame(8'h55, 1'b0, -1, t0);
      repeat (20 * C) @(negedge clk);
      check("brk_ferr", n_ferr - f0, 1);
      check("brk_strobes", rx_q.size() - n0, 0);
      check("brk_data", data, 8'h41);
      check("brk_busy", busy, 1'b1);
      serial_rxd = 1'b1;
      repeat (4) @(negedge clk);
      check("brk_exit_busy", busy, 1'b0);
      send_frame(8'hA5, 1'b1, -1, t0);
      repeat (C) @(negedge clk);
      check("brk_after_strobes", rx_q.size() - n0, 1);
      check("brk_after_data", data, 8'hA5);

      // Reset pulse in the middle of data bit 4.
      b  = 8'hA5;
      n0 = rx_q.size();
      serial_rxd = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         serial_rxd = b[i];
         repeat (C) @(negedge clk);
      end
      serial_rxd = b[4];
      repeat (H) @(negedge clk);
      check("rst_pre_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_data", data, 8'h00);
      check("rst_strobe", data_strobe, 1'b0);
      check("rst_ferr", framing_error, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset      = 1'b0;
      serial_rxd = 1'b1;
      repeat (2 * C) @(negedge clk);
      check("rst_no_strobe", rx_q.size() - n0, 0);
      send_frame(8'hA5, 1'b1, -1, t0);
      repeat (C) @(negedge clk);
      check("rst_after_data", data, 8'hA5);
      check("rst_after_strobes", rx_q.size() - n0, 1);

      // One-cycle inversion at the bit-3 sample point of a 0x00 frame.
`ifdef UART_RX_MAJORITY_EN
      exp_glitch = 8'h00;
`else
      exp_glitch = 8'h08;
`endif
      n0 = rx_q.size();
      send_frame(8'h00, 1'b1, 3, t0);
      repeat (C) @(negedge clk);
      check("pglitch_strobes", rx_q.size() - n0, 1);
      check("pglitch_data", data, exp_glitch);

      check("strobe_exclusive", n_both, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
